// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - command sequencer in front of the 16-bit ALU; `ALU_ISSUE_CHAIN_EN adds accumulator chaining
module alu_issue #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_y,
  input  logic             cmd_zx,
  input  logic             cmd_zy,
  input  logic             cmd_no,
  input  logic [OP_W-1:0]  cmd_op,
`ifdef ALU_ISSUE_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_zy,
  output logic             alu_no,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_is_negative,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           r_state;
  logic             w_accept;
  logic [WIDTH-1:0] w_x_src;

  // A result being drained in RESP frees the slot for the next command in the same cycle.
  assign cmd_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & res_ready);
  assign w_accept  = cmd_valid & cmd_ready;

`ifdef ALU_ISSUE_CHAIN_EN
  logic [WIDTH-1:0] r_bypass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bypass <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_bypass <= alu_result;
    end
  end

  assign w_x_src = cmd_chain ? r_bypass : cmd_x;
`else
  assign w_x_src = cmd_x;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_zx    <= 1'b0;
      alu_zy    <= 1'b0;
      alu_no    <= 1'b0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
    end else begin
      // ALU drive registers only move on an accept, so they stay stable through ISSUE.
      if (w_accept) begin
        alu_x  <= w_x_src;
        alu_y  <= cmd_y;
        alu_zx <= cmd_zx;
        alu_zy <= cmd_zy;
        alu_no <= cmd_no;
        alu_op <= cmd_op;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // ALU is_zero is pre-negation, so zero is recomputed from the final value.
          res_data  <= alu_result;
          res_zero  <= (alu_result == '0);
          res_neg   <= alu_is_negative;
          res_valid <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= w_accept ? S_ISSUE : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - vector table, directed corner sequences and random traffic for alu_issue
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_x;
  logic [15:0] cmd_y;
  logic        cmd_zx;
  logic        cmd_zy;
  logic        cmd_no;
  logic [1:0]  cmd_op;
`ifdef ALU_ISSUE_CHAIN_EN
  logic        cmd_chain;
`endif
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx;
  logic        alu_zy;
  logic        alu_no;
  logic [1:0]  alu_op;
  logic [15:0] alu_result = 16'h0;
  logic        alu_is_negative = 1'b0;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_zero;
  logic        res_neg;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] prev_res;

  alu_issue #(.WIDTH(16), .OP_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_zx(cmd_zx), .cmd_zy(cmd_zy),
    .cmd_no(cmd_no), .cmd_op(cmd_op),
`ifdef ALU_ISSUE_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_zy(alu_zy),
    .alu_no(alu_no), .alu_op(alu_op),
    .alu_result(alu_result), .alu_is_negative(alu_is_negative),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_neg(res_neg)
  );

  always #5 clk = ~clk;

  // {is_negative, result} of the 16-bit ALU
  function automatic logic [16:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic zx, input logic zy, input logic no,
                                          input logic [1:0] op);
    logic [15:0] a, b, f;
    a = zx ? 16'h0 : x;
    b = zy ? 16'h0 : y;
    case (op)
      2'd0:    f = a | b;
      2'd1:    f = a & b;
      2'd2:    f = a + b;
      default: f = a - b;
    endcase
    if (no) f = ~f;
    return {f[15], f};
  endfunction

  logic [16:0] alu_f;
  assign alu_f = ref_alu(alu_x, alu_y, alu_zx, alu_zy, alu_no, alu_op);

  // One-cycle registered ALU standing in for the real one
  always @(posedge clk) begin
    alu_result      <= alu_f[15:0];
    alu_is_negative <= alu_f[16];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one command, wait for its accept, then wait for res_valid; returns edges from accept.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic zx,
                       input logic zy, input logic no, input logic [1:0] op,
                       input logic chain, output int edges);
    int n;
    logic [15:0] exp_ax;
    exp_ax = chain ? prev_res : x;
    cmd_x = x; cmd_y = y; cmd_zx = zx; cmd_zy = zy; cmd_no = no; cmd_op = op;
`ifdef ALU_ISSUE_CHAIN_EN
    cmd_chain = chain;
`endif
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_x = 16'($urandom); cmd_y = 16'($urandom); cmd_op = 2'($urandom);
`ifdef ALU_ISSUE_CHAIN_EN
    cmd_chain = 1'($urandom);
`endif
    edges = 0;
    while (!res_valid && edges < 10) begin
      @(posedge clk); #1; edges++;
    end
    check("alu_x_drive", 32'(alu_x), 32'(exp_ax));
    check("alu_ctl_drive", 32'({alu_y, alu_zx, alu_zy, alu_no, alu_op}),
          32'({y, zx, zy, no, op}));
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        zx;
    logic        zy;
    logic        no;
    logic [1:0]  op;
    logic [15:0] e_data;
    logic        e_zero;
    logic        e_neg;
  } vec_t;

  vec_t tbl[10];

  initial begin : main
    int edges;
    int t, nres;
    logic armed;
    logic ghost;
    int rt[2];
    logic [15:0] rd[2];
    logic [15:0] rx, ry;
    logic rzx, rzy, rno, rch;
    logic [1:0] rop;
    logic [16:0] ex;

    tbl[0] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 2'd2, 16'h0007, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1, 2'd3, 16'hFFFF, 1'b0, 1'b1};
    tbl[3] = '{16'h00F0, 16'h000F, 1'b0, 1'b0, 1'b0, 2'd0, 16'h00FF, 1'b0, 1'b0};
    tbl[4] = '{16'h0FF0, 16'h00FF, 1'b0, 1'b0, 1'b0, 2'd1, 16'h00F0, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd2, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h1234, 16'h0005, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0005, 1'b0, 1'b0};
    tbl[7] = '{16'h0010, 16'h0099, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0010, 1'b0, 1'b0};
    tbl[8] = '{16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd3, 16'hFFFF, 1'b0, 1'b1};
    tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_x = 16'h0; cmd_y = 16'h0; cmd_zx = 1'b0; cmd_zy = 1'b0; cmd_no = 1'b0; cmd_op = 2'd0;
`ifdef ALU_ISSUE_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    prev_res = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu", 32'({alu_x, alu_zx, alu_zy, alu_no, alu_op}), 32'd0);
    check("rst_alu_y", 32'(alu_y), 32'd0);
    check("rst_res", 32'({res_valid, res_data, res_zero, res_neg}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_idle_ready", 32'(cmd_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      res_ready = 1'b0;
      issue(tbl[i].x, tbl[i].y, tbl[i].zx, tbl[i].zy, tbl[i].no, tbl[i].op, 1'b0, edges);
      check($sformatf("tbl%0d_latency", i), 32'(edges), 32'd2);
      check($sformatf("tbl%0d_data", i), 32'(res_data), 32'(tbl[i].e_data));
      check($sformatf("tbl%0d_flags", i), 32'({res_zero, res_neg}), 32'({tbl[i].e_zero, tbl[i].e_neg}));
      prev_res = tbl[i].e_data;
      consume();
    end

    // Backpressure: result held, no accept while stalled
    res_ready = 1'b0;
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, edges);
    check("bp_latency", 32'(edges), 32'd2);
    cmd_x = 16'h1111; cmd_y = 16'h2222; cmd_op = 2'd0; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", 32'({res_valid, res_data, res_neg, res_zero}), 32'({1'b1, 16'h8000, 1'b1, 1'b0}));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    prev_res = 16'h8000;
    consume();
    check("bp_no_accept", 32'(alu_x), 32'h7FFF);

    // Back-to-back: second command accepted in RESP as the first result drains
    res_ready = 1'b1;
    cmd_x = 16'h00F0; cmd_y = 16'h000F; cmd_zx = 1'b0; cmd_zy = 1'b0; cmd_no = 1'b0; cmd_op = 2'd0;
`ifdef ALU_ISSUE_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_x = 16'h0FF0; cmd_y = 16'h00FF; cmd_op = 2'd1;
    t = 0; nres = 0; armed = 1'b0;
    rt[0] = 0; rt[1] = 0; rd[0] = 16'h0; rd[1] = 16'h0;
    while (nres < 2 && t < 20) begin
      @(posedge clk); #1; t++;
      if (armed) begin
        cmd_valid = 1'b0;
        armed = 1'b0;
      end
      if (res_valid) begin
        rt[nres] = t;
        rd[nres] = res_data;
        if (nres == 0) begin
          check("b2b_ready", 32'(cmd_ready), 32'd1);
          armed = 1'b1;
        end
        nres++;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_first", 32'(rd[0]), 32'h00FF);
    check("b2b_second", 32'(rd[1]), 32'h00F0);
    check("b2b_first_time", 32'(rt[0]), 32'd2);
    check("b2b_spacing", 32'(rt[1] - rt[0]), 32'd3);
    prev_res = 16'h00F0;
    consume();

    // Reset while the ALU is busy
    res_ready = 1'b0;
    cmd_x = 16'h1111; cmd_y = 16'h2222; cmd_op = 2'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_issue_x", 32'(alu_x), 32'h1111);
    rst = 1'b0;
    #1;
    check("mid_rst_alu", 32'({alu_x, alu_y}), 32'd0);
    check("mid_rst_ctl", 32'({alu_zx, alu_zy, alu_no, alu_op}), 32'd0);
    check("mid_rst_res", 32'({res_valid, res_data, res_zero, res_neg}), 32'd0);
    #2 rst = 1'b1;
    prev_res = 16'h0;
    res_ready = 1'b1;
    ghost = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      ghost = ghost | res_valid;
    end
    check("mid_rst_no_ghost", 32'(ghost), 32'd0);

`ifdef ALU_ISSUE_CHAIN_EN
    res_ready = 1'b0;
    issue(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, edges);
    check("chain_first", 32'(res_data), 32'h0005);
    prev_res = 16'h0005;
    consume();
    res_ready = 1'b0;
    issue(16'hDEAD, 16'h000A, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, edges);
    check("chain_second", 32'(res_data), 32'h000F);
    prev_res = 16'h000F;
    consume();
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      rzx = ($urandom_range(0, 7) == 0); rzy = ($urandom_range(0, 7) == 0);
      rno = 1'($urandom); rop = 2'($urandom);
`ifdef ALU_ISSUE_CHAIN_EN
      rch = 1'($urandom);
`else
      rch = 1'b0;
`endif
      ex = ref_alu(rch ? prev_res : rx, ry, rzx, rzy, rno, rop);
      res_ready = 1'b0;
      issue(rx, ry, rzx, rzy, rno, rop, rch, edges);
      check($sformatf("rnd%0d_latency", i), 32'(edges), 32'd2);
      check($sformatf("rnd%0d_data", i), 32'(res_data), 32'(ex[15:0]));
      check($sformatf("rnd%0d_flags", i), 32'({res_zero, res_neg}),
            32'({ex[15:0] == 16'h0, ex[16]}));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        @(posedge clk); #1;
        check($sformatf("rnd%0d_hold", i), 32'({res_valid, res_data}), 32'({1'b1, ex[15:0]}));
      end
      prev_res = ex[15:0];
      consume();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Command sequencer directly upstream of the 16-bit ALU.
- Accepts operand/control commands over a valid/ready handshake and holds the ALU control and data inputs stable for the ALU's one-cycle registered latency.
- Captures the ALU result and flags, then presents them downstream over a second valid/ready handshake.
- Sits between the instruction decode/register-read stage and writeback.

Parameters:
- WIDTH, 16, datapath width; fixed at 16 to match the ALU.
- OP_W, 2, opcode width: 0=OR, 1=AND, 2=ADD, 3=SUB.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- cmd_valid  in  1  upstream command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_x  in  WIDTH  operand x
- cmd_y  in  WIDTH  operand y
- cmd_zx  in  1  zero x
- cmd_zy  in  1  zero y
- cmd_no  in  1  negate output
- cmd_op  in  OP_W  ALU opcode
- alu_x, alu_y  out  WIDTH  to ALU x/y
- alu_zx, alu_zy, alu_no  out  1  to ALU zero_x/zero_y/negate_output
- alu_op  out  OP_W  to ALU opcode
- alu_result  in  WIDTH  from ALU output_result
- alu_is_negative  in  1  from ALU is_negative
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  WIDTH  captured result, post-negation
- res_zero  out  1  res_data == 0, computed locally
- res_neg  out  1  captured alu_is_negative

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- Reset (rst=0, async): state=IDLE. All alu_* outputs=0, res_data=0, res_zero=0, res_neg=0, res_valid=0.
  - Reset mid-operation discards any in-flight command; no partial result is presented.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register all cmd_* into the alu_* drive registers, then go to ISSUE.
- ISSUE: alu_* held stable; the ALU registers its result at the end of this cycle. Next state is CAPTURE.
- CAPTURE: alu_result is valid.
  - Register res_data=alu_result, res_neg=alu_is_negative, res_zero=(alu_result==0).
  - Go to RESP.
- Flag source: the ALU's is_zero is pre-negation, so it is not used. res_zero always reflects res_data.
- RESP: res_valid=1. res_data/res_zero/res_neg are held stable until res_ready=1.
  - On res_ready=1 with no new command: go to IDLE, res_valid=0 next cycle.
- Back-to-back: cmd_ready = (state==IDLE) | (state==RESP & res_ready).
  - A command accepted in RESP while the result is consumed goes directly to ISSUE.
  - Sustained throughput: one command per 3 cycles.
- Latency: command accepted at edge E0 gives res_valid=1 after E2.
- alu_* outputs keep the last issued values while in IDLE/RESP; they change only on accept.
- cmd_* are sampled only on an accept edge; changes at other times are ignored.
- Arithmetic is performed by the ALU; ADD/SUB wrap modulo 2^16. The block does no arithmetic except the zero compare.
- cmd_ready never depends combinationally on cmd_valid. res_valid never depends combinationally on res_ready.

Optional Feature:
- Macro: ALU_ISSUE_CHAIN_EN
- With the macro: extra input cmd_chain (1 bit).
  - When an accepted command has cmd_chain=1, alu_x is driven from the bypass register instead of cmd_x.
  - The bypass register holds the last res_data and is written at each CAPTURE.
  - The bypass register resets to 0.
  - In the back-to-back RESP accept case, the bypass uses the current res_data.
  - This enables accumulator chaining.
- Without the macro: no cmd_chain port, no bypass register; alu_x always comes from cmd_x.

Test Plan:
- Reset then single ADD x=0x0003 y=0x0004 op=2 → after 2 edges res_valid=1, res_data=0x0007, res_zero=0, res_neg=0.
- SUB x=0x0005 y=0x0005 op=3 no=0 → res_data=0x0000, res_zero=1. Same with no=1 → res_data=0xFFFF, res_zero=0, res_neg=1.
- Backpressure: ADD 0x7FFF+0x0001, hold res_ready=0 for 5 cycles → res_data=0x8000 stable, res_neg=1, cmd_ready=0 throughout.
- Back-to-back: cmd_valid held with OR 0x00F0|0x000F, then AND 0x0FF0&0x00FF, res_ready=1 → results 0x00FF then 0x00F0, 3 cycles apart.
- Mid-operation reset: drive rst=0 in ISSUE → all outputs 0 immediately. After release, no res_valid until a new command.
- (ALU_ISSUE_CHAIN_EN) ADD 2+3, then chained ADD y=10 with cmd_x=0xDEAD → second res_data=0x000F.
